// File: rtl/piano_key_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : piano_key_scanner_if
// Description : Key/button inputs and note/octave outputs of the piano
//               key scanner. The scanner is the master, consumers the slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface piano_key_scanner_if;
  // Raw keys C..B (a..g) and octave buttons
  logic       a;
  logic       b;
  logic       c;
  logic       d;
  logic       e;
  logic       f;
  logic       g;
  logic       up;
  logic       down;
  // Conditioned outputs
  logic [2:0] note_code;
  logic       note_valid;
  logic       note_strobe;
  logic [2:0] octave;
  logic       oct_strobe;

  modport master (
    input  a, b, c, d, e, f, g, up, down,
    output note_code, note_valid, note_strobe, octave, oct_strobe
  );

  modport slave (
    output a, b, c, d, e, f, g, up, down,
    input  note_code, note_valid, note_strobe, octave, oct_strobe
  );
endinterface
`default_nettype wire

// File: rtl/piano_key_scanner.sv
`default_nettype none
// ============================================================================
// Module      : piano_key_scanner
// Description : Synchronises and debounces the note keys a..g and the octave
//               buttons, then produces a registered priority note code, a
//               saturating octave counter and single-cycle change strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module piano_key_scanner #(
  parameter int DEB_CYCLES = 4,
  parameter int OCT_MIN    = 0,
  parameter int OCT_MAX    = 7,
  parameter int OCT_RESET  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  piano_key_scanner_if.master  bus
);

  localparam int              C_N_IN      = 9;
  localparam int              C_CNT_W     = $clog2(DEB_CYCLES + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEB_CYCLES - 1);
  localparam logic [2:0]      C_OCT_MIN   = 3'(OCT_MIN);
  localparam logic [2:0]      C_OCT_MAX   = 3'(OCT_MAX);
  localparam logic [2:0]      C_OCT_RESET = 3'(OCT_RESET);
  // Bit positions inside the input vector: keys 0..6, then up, down
  localparam int              C_IDX_UP    = 7;
  localparam int              C_IDX_DOWN  = 8;

  logic [C_N_IN-1:0] w_raw;
  logic [C_N_IN-1:0] r_sync1;
  logic [C_N_IN-1:0] r_sync2;
  logic [C_N_IN-1:0] w_deb;

  logic [2:0] w_next_code;
  logic [2:0] w_next_oct;
  logic       w_up_edge;
  logic       w_down_edge;

  logic       r_up_prev;
  logic       r_down_prev;
  logic [2:0] r_note_code;
  logic       r_note_valid;
  logic       r_note_strobe;
  logic [2:0] r_octave;
  logic       r_oct_strobe;

  assign w_raw = {bus.down, bus.up, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a};

  // Two-flop synchroniser for every raw input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  generate
    for (genvar i = 0; i < C_N_IN; i++) begin : g_deb
      logic [C_CNT_W-1:0] r_cnt;
      logic               r_state;

      // Accept a change only after it has disagreed with the state for
      // DEB_CYCLES consecutive synchronised samples
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt   <= '0;
          r_state <= 1'b0;
        end else if (r_sync2[i] == r_state) begin
          r_cnt   <= '0;
        end else if (r_cnt == C_CNT_LAST) begin
          r_state <= ~r_state;
          r_cnt   <= '0;
        end else begin
          r_cnt   <= r_cnt + 1'b1;
        end
      end

      assign w_deb[i] = r_state;
    end
  endgenerate

  // Priority encoder: key a wins over b, and so on down to g
  always_comb begin
    w_next_code = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (w_deb[i]) begin
        w_next_code = 3'(i + 1);
      end
    end
  end

  assign w_up_edge   = w_deb[C_IDX_UP]   & ~r_up_prev;
  assign w_down_edge = w_deb[C_IDX_DOWN] & ~r_down_prev;

  // Saturating octave step; simultaneous edges cancel
  always_comb begin
    w_next_oct = r_octave;
    if (w_up_edge && !w_down_edge && (r_octave < C_OCT_MAX)) begin
      w_next_oct = r_octave + 3'd1;
    end else if (w_down_edge && !w_up_edge && (r_octave > C_OCT_MIN)) begin
      w_next_oct = r_octave - 3'd1;
    end
  end

  // Registered note/octave outputs and their change strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_note_code   <= 3'd0;
      r_note_valid  <= 1'b0;
      r_note_strobe <= 1'b0;
      r_octave      <= C_OCT_RESET;
      r_oct_strobe  <= 1'b0;
      r_up_prev     <= 1'b0;
      r_down_prev   <= 1'b0;
    end else begin
      r_note_code   <= w_next_code;
      r_note_valid  <= (w_next_code != 3'd0);
      r_note_strobe <= (w_next_code != 3'd0) && (w_next_code != r_note_code);
      r_octave      <= w_next_oct;
      r_oct_strobe  <= (w_next_oct != r_octave);
      r_up_prev     <= w_deb[C_IDX_UP];
      r_down_prev   <= w_deb[C_IDX_DOWN];
    end
  end

  assign bus.note_code   = r_note_code;
  assign bus.note_valid  = r_note_valid;
  assign bus.note_strobe = r_note_strobe;
  assign bus.octave      = r_octave;
  assign bus.oct_strobe  = r_oct_strobe;

endmodule
`default_nettype wire

// File: tb/tb_piano_key_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_piano_key_scanner
// Description : Directed stimulus for piano_key_scanner with a behavioural
//               reference model compared every cycle, plus literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piano_key_scanner;

  localparam int DEB_CYCLES = 4;
  localparam int OCT_MIN    = 0;
  localparam int OCT_MAX    = 7;
  localparam int OCT_RESET  = 4;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  piano_key_scanner_if pif ();

  piano_key_scanner #(
    .DEB_CYCLES (DEB_CYCLES),
    .OCT_MIN    (OCT_MIN),
    .OCT_MAX    (OCT_MAX),
    .OCT_RESET  (OCT_RESET)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (pif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  // Each input: raw seen two edges late; the accepted level flips once the
  // seen level has disagreed with it for DEB_CYCLES samples in a row.
  logic [8:0] m_s1 = '0, m_s2 = '0, m_deb = '0;
  int         m_run [9];
  int         m_code = 0, m_oct = OCT_RESET;
  logic       m_valid = 0, m_nstb = 0, m_ostb = 0;
  logic       m_up_prev = 0, m_dn_prev = 0;

  always @(posedge clk or negedge rst_n) begin : model
    int nc, no;
    logic upe, dne;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0;
      for (int i = 0; i < 9; i++) m_run[i] = 0;
      m_code = 0; m_valid = 0; m_nstb = 0;
      m_oct = OCT_RESET; m_ostb = 0;
      m_up_prev = 0; m_dn_prev = 0;
    end else begin
      nc = 0;
      for (int i = 6; i >= 0; i--) if (m_deb[i]) nc = i + 1;
      m_nstb  = (nc != 0) && (nc != m_code);
      m_code  = nc;
      m_valid = (nc != 0);
      upe = m_deb[7] && !m_up_prev;
      dne = m_deb[8] && !m_dn_prev;
      no  = m_oct;
      if (upe && !dne) no = (m_oct < OCT_MAX) ? m_oct + 1 : m_oct;
      if (dne && !upe) no = (m_oct > OCT_MIN) ? m_oct - 1 : m_oct;
      m_ostb = (no != m_oct);
      m_oct  = no;
      m_up_prev = m_deb[7];
      m_dn_prev = m_deb[8];
      for (int i = 0; i < 9; i++) begin
        if (m_s2[i] == m_deb[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] == DEB_CYCLES) begin
            m_deb[i] = ~m_deb[i];
            m_run[i] = 0;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = {pif.down, pif.up, pif.g, pif.f, pif.e, pif.d, pif.c, pif.b, pif.a};
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("cyc note_code",   {5'd0, pif.note_code}, 8'(m_code));
    check("cyc note_valid",  {7'd0, pif.note_valid}, {7'd0, m_valid});
    check("cyc note_strobe", {7'd0, pif.note_strobe}, {7'd0, m_nstb});
    check("cyc octave",      {5'd0, pif.octave}, 8'(m_oct));
    check("cyc oct_strobe",  {7'd0, pif.oct_strobe}, {7'd0, m_ostb});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_oct(input bit use_up, input bit use_dn,
                           input logic [2:0] exp_oct, input logic exp_stb,
                           input string tag);
    if (use_up) pif.up = 1'b1;
    if (use_dn) pif.down = 1'b1;
    step(7);
    check({tag, " octave"}, {5'd0, pif.octave}, {5'd0, exp_oct});
    check({tag, " oct_strobe"}, {7'd0, pif.oct_strobe}, {7'd0, exp_stb});
    step(1);
    check({tag, " oct_strobe drop"}, {7'd0, pif.oct_strobe}, 8'd0);
    pif.up   = 1'b0;
    pif.down = 1'b0;
    step(8);
  endtask

  initial begin
    logic [2:0] up_exp [5];
    logic       up_stb [5];
    up_exp = '{3'd5, 3'd6, 3'd7, 3'd7, 3'd7};
    up_stb = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    {pif.a, pif.b, pif.c, pif.d, pif.e, pif.f, pif.g, pif.up, pif.down} = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    step(3);
    check("reset note_code", {5'd0, pif.note_code}, 8'd0);
    check("reset note_valid", {7'd0, pif.note_valid}, 8'd0);
    check("reset octave", {5'd0, pif.octave}, 8'd4);
    rst_n = 1'b1;
    step(2);

    // 1: single key, 7-edge latency, one strobe
    pif.a = 1'b1;
    step(6);
    check("t1 code before", {5'd0, pif.note_code}, 8'd0);
    step(1);
    check("t1 code", {5'd0, pif.note_code}, 8'd1);
    check("t1 valid", {7'd0, pif.note_valid}, 8'd1);
    check("t1 strobe", {7'd0, pif.note_strobe}, 8'd1);
    check("t1 octave", {5'd0, pif.octave}, 8'd4);
    step(1);
    check("t1 strobe drop", {7'd0, pif.note_strobe}, 8'd0);
    step(3);

    // 2: 3-cycle glitches on c are ignored, then c takes over from a
    for (int k = 0; k < 3; k++) begin
      pif.c = 1'b1; step(3);
      pif.c = 1'b0; step(3);
    end
    check("t2 glitch code", {5'd0, pif.note_code}, 8'd1);
    pif.c = 1'b1;
    pif.a = 1'b0;
    step(6);
    check("t2 code before", {5'd0, pif.note_code}, 8'd1);
    step(1);
    check("t2 code", {5'd0, pif.note_code}, 8'd3);
    check("t2 strobe", {7'd0, pif.note_strobe}, 8'd1);
    pif.c = 1'b0;
    step(10);

    // 3: priority between b and e, release behaviour
    pif.b = 1'b1; pif.e = 1'b1;
    step(7);
    check("t3 code b", {5'd0, pif.note_code}, 8'd2);
    step(3);
    pif.b = 1'b0;
    step(7);
    check("t3 code e", {5'd0, pif.note_code}, 8'd5);
    check("t3 strobe e", {7'd0, pif.note_strobe}, 8'd1);
    step(3);
    pif.e = 1'b0;
    step(7);
    check("t3 code rel", {5'd0, pif.note_code}, 8'd0);
    check("t3 valid rel", {7'd0, pif.note_valid}, 8'd0);
    check("t3 strobe rel", {7'd0, pif.note_strobe}, 8'd0);
    step(3);

    // 4: octave up with saturation
    for (int k = 0; k < 5; k++) press_oct(1'b1, 1'b0, up_exp[k], up_stb[k], "t4 up");

    // 5: octave down with saturation, then simultaneous up+down
    for (int k = 0; k < 9; k++)
      press_oct(1'b0, 1'b1, (k < 7) ? 3'(6 - k) : 3'd0, (k < 7), "t5 down");
    press_oct(1'b1, 1'b0, 3'd1, 1'b1, "t5 up");
    press_oct(1'b1, 1'b1, 3'd1, 1'b0, "t5 both");

    // 6: reset while keys are held
    pif.g = 1'b1; pif.up = 1'b1;
    step(10);
    check("t6 code held", {5'd0, pif.note_code}, 8'd7);
    check("t6 octave held", {5'd0, pif.octave}, 8'd2);
    rst_n = 1'b0;
    #1;
    check("t6 code in reset", {5'd0, pif.note_code}, 8'd0);
    check("t6 valid in reset", {7'd0, pif.note_valid}, 8'd0);
    check("t6 octave in reset", {5'd0, pif.octave}, 8'd4);
    step(2);
    rst_n = 1'b1;
    step(6);
    check("t6 code before", {5'd0, pif.note_code}, 8'd0);
    check("t6 octave before", {5'd0, pif.octave}, 8'd4);
    step(1);
    check("t6 code", {5'd0, pif.note_code}, 8'd7);
    check("t6 octave", {5'd0, pif.octave}, 8'd5);
    check("t6 note_strobe", {7'd0, pif.note_strobe}, 8'd1);
    check("t6 oct_strobe", {7'd0, pif.oct_strobe}, 8'd1);
    step(1);
    check("t6 note_strobe drop", {7'd0, pif.note_strobe}, 8'd0);
    check("t6 oct_strobe drop", {7'd0, pif.oct_strobe}, 8'd0);
    pif.g = 1'b0; pif.up = 1'b0;
    step(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/piano_key_scanner.md
Name: piano_key_scanner

Overview:
- Input-side front end of the electronic piano. It conditions the raw note keys a..g and the octave buttons up/down.
- It produces a clean, registered note code, an octave number and single-cycle event strobes.
- These outputs drive the seven-segment display path and the tone generator. This block is the producer; those blocks consume its outputs.
- All outputs are glitch-free. Every stored value is owned by this block.

Parameters:
DEB_CYCLES, 4, consecutive stable cycles needed to accept an input change (sim value; board builds use 50000)
OCT_MIN, 0, lowest octave value
OCT_MAX, 7, highest octave value
OCT_RESET, 4, octave value after reset (OCT_MIN <= OCT_RESET <= OCT_MAX)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active-low
a  input  1  raw key C (do), active-high, asynchronous to clk, bouncy
b  input  1  raw key D (re)
c  input  1  raw key E (mi)
d  input  1  raw key F (fa)
e  input  1  raw key G (sol)
f  input  1  raw key A (la)
g  input  1  raw key B (si)
up  input  1  raw octave-up button, active-high
down  input  1  raw octave-down button, active-high
note_code  output  3  0 = no key; 1..7 = a..g
note_valid  output  1  high while any debounced key is pressed
note_strobe  output  1  one-cycle pulse when note_code changes to a nonzero value
octave  output  3  current octave, OCT_MIN..OCT_MAX
oct_strobe  output  1  one-cycle pulse when octave actually changes

Behaviour:
Clock and reset:
- One clock domain: clk. Asynchronous active-low reset rst_n.
- During reset: note_code=0, note_valid=0, note_strobe=0, octave=OCT_RESET, oct_strobe=0.
- All synchronizer flops, debounce counters and debounced states are cleared to 0 during reset.

Synchronizer:
- Each of the 9 raw inputs passes through its own 2-flop synchronizer.

Debounce (one instance per input):
- State: debounced bit S and counter CNT, width clog2(DEB_CYCLES+1).
- When the synced input equals S: CNT clears to 0.
- When the synced input differs from S: CNT increments. On the cycle CNT reaches DEB_CYCLES-1, S toggles and CNT clears.
- A bounce shorter than DEB_CYCLES cycles never changes S.

Note encoding (registered):
- Priority is a > b > ... > g.
- note_code takes the index of the highest-priority key whose S=1; it is 0 if no key is pressed.
- note_valid = (next note_code != 0), registered together with note_code.
- note_strobe pulses in the cycle note_code changes to a nonzero value, including a direct change from one key to another.
- There is no strobe on release to 0.

Octave logic:
- Edges are taken on the debounced up/down bits (S rising 0->1).
- up edge alone: octave+1, saturating at OCT_MAX.
- down edge alone: octave-1, saturating at OCT_MIN.
- up and down edges in the same cycle: no change, no strobe.
- oct_strobe pulses one cycle only when the octave value actually changes. Saturated presses give no pulse.
- Holding a button gives exactly one step; there is no auto-repeat.

Latency:
- A raw level change that stays stable reaches its debounced S DEB_CYCLES+2 edges after it is first sampled.
- note_code, note_valid, octave and both strobes update 1 edge after that, i.e. DEB_CYCLES+3 edges total.

Reset mid-operation:
- Asserting rst_n mid-operation immediately forces all reset values.
- After release, keys still held are re-debounced from scratch. Held keys then produce a fresh note_strobe.
- Held up/down buttons produce an edge after release: the debounced S rises 0->1 again, so a held button steps the octave once from OCT_RESET.

Test Plan:
1. Reset, then hold a=1 (DEB_CYCLES=4) -> 7 edges later note_code=1, note_valid=1, note_strobe high for exactly 1 cycle; octave=4 throughout.
2. With a debounced, toggle c with 3-cycle glitches, then hold c steady while releasing a -> glitches ignored; note_code goes 1->3 with one note_strobe.
3. Press b and e together -> note_code=2; then release b -> note_code=5 with a note_strobe; then release e -> note_code=0, note_valid=0, no strobe.
4. Press up 5 times (each held >= 8 cycles, gaps >= 8 cycles) from reset -> octave 5,6,7,7,7; oct_strobe pulses 3 times only.
5. Press down 9 times -> octave falls to 0 and saturates; then up and down rising on the same debounced cycle -> octave unchanged, no oct_strobe.
6. Hold g and up, then pulse rst_n low for 2 cycles -> outputs immediately 0/OCT_RESET. After release: note_code=7 and octave=5, 7 edges later, each with a single strobe.
